// File: rtl/wwd_checker.sv
// rtl/wwd_checker.sv - synthesizable WWD answer checker with cycle counter and pass/fail summary
//
// Purpose: watches num_inst / output_port / is_halted of the pipeline CPU and
// compares each retired-instruction milestone against a loadable table of
// expected WWD answers. At the end of a run it produces a per-entry status
// and pass/fail/no-result counts.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   start, clear                      run control (start in IDLE, clear in DONE)
//   tbl_we, tbl_addr, tbl_inst, tbl_ans   table load port (IDLE only)
//   num_inst, output_port, is_halted  observed CPU signals
//   stat_addr, stat_q                 per-entry status read (0 NONE, 1 PASS, 2 FAIL)
//   busy, done, all_pass              run state and overall verdict
//   timeout, cfg_err                  sticky error flags
//   pass_cnt, fail_cnt, nores_cnt     summary counts
//   first_fail_idx, first_fail_val    first failing entry and the value seen
//   cycle_count                       RUN cycles elapsed
//
// Build option: WWD_CHECKER_STOP_ON_FAIL_EN ends the run on the first FAIL.

module wwd_checker #(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_TEST   = 56,
  parameter int IDX_W      = 6,
  parameter int MAX_CYCLES = 10000,
  parameter int CYC_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 tbl_we,
  input  logic [IDX_W-1:0]     tbl_addr,
  input  logic [WORD_SIZE-1:0] tbl_inst,
  input  logic [WORD_SIZE-1:0] tbl_ans,
  input  logic [WORD_SIZE-1:0] num_inst,
  input  logic [WORD_SIZE-1:0] output_port,
  input  logic                 is_halted,
  input  logic [IDX_W-1:0]     stat_addr,
  output logic [1:0]           stat_q,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic                 timeout,
  output logic                 cfg_err,
  output logic [IDX_W:0]       pass_cnt,
  output logic [IDX_W:0]       fail_cnt,
  output logic [IDX_W:0]       nores_cnt,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [WORD_SIZE-1:0] first_fail_val,
  output logic [CYC_W-1:0]     cycle_count
);

  localparam logic [1:0]       ST_NONE  = 2'd0;
  localparam logic [1:0]       ST_PASS  = 2'd1;
  localparam logic [1:0]       ST_FAIL  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEST - 1);
  localparam logic [IDX_W:0]   SUM_END  = (IDX_W + 1)'(NUM_TEST);
  localparam logic [CYC_W-1:0] TMO_CYC  = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SUMMARY, S_DONE} state_t;

  state_t state, state_nxt;

  // Table RAM is deliberately not reset so a loaded table survives reset.
  logic [WORD_SIZE-1:0] tbl_inst_mem [NUM_TEST];
  logic [WORD_SIZE-1:0] tbl_ans_mem  [NUM_TEST];
  logic [1:0]           status       [NUM_TEST];

  logic [IDX_W-1:0]     ptr;
  logic [IDX_W:0]       sum_idx;
  logic [WORD_SIZE-1:0] prev_inst;
  logic                 fail_seen;

  logic [WORD_SIZE-1:0] cur_inst;
  logic [WORD_SIZE-1:0] cur_ans;
  logic                 hit;
  logic                 mism;
  logic                 tmo_hit;
  logic                 run_exit;

  assign cur_inst = tbl_inst_mem[ptr];
  assign cur_ans  = tbl_ans_mem[ptr];
  assign hit      = (num_inst == cur_inst);
  assign mism     = (output_port != cur_ans);
  assign tmo_hit  = (cycle_count == TMO_CYC);

`ifdef WWD_CHECKER_STOP_ON_FAIL_EN
  assign run_exit = is_halted || tmo_hit || (hit && mism);
`else
  assign run_exit = is_halted || tmo_hit;
`endif

  always_ff @(posedge clk) begin
    if (state == S_IDLE && tbl_we && int'(tbl_addr) < NUM_TEST) begin
      tbl_inst_mem[tbl_addr] <= tbl_inst;
      tbl_ans_mem[tbl_addr]  <= tbl_ans;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RUN;
      S_RUN:     if (run_exit) state_nxt = S_SUMMARY;
      // One extra SUMMARY cycle after the last entry lets the final tally settle.
      S_SUMMARY: if (sum_idx == SUM_END) state_nxt = S_DONE;
      S_DONE:    if (clear) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_RUN) || (state == S_SUMMARY);
    done     = (state == S_DONE);
    all_pass = (state == S_DONE) && (pass_cnt == SUM_END) && !timeout && !cfg_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_TEST; i++) status[i] <= ST_NONE;
      ptr            <= '0;
      sum_idx        <= '0;
      prev_inst      <= '0;
      fail_seen      <= 1'b0;
      timeout        <= 1'b0;
      cfg_err        <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      nores_cnt      <= '0;
      first_fail_idx <= '0;
      first_fail_val <= '0;
      cycle_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_TEST; i++) status[i] <= ST_NONE;
            ptr            <= '0;
            sum_idx        <= '0;
            fail_seen      <= 1'b0;
            timeout        <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            nores_cnt      <= '0;
            first_fail_idx <= '0;
            first_fail_val <= '0;
            cycle_count    <= '0;
          end
        end
        S_RUN: begin
          // The timeout cycle holds the count so it reads MAX_CYCLES-1 at the end.
          if (tmo_hit) timeout <= 1'b1;
          else if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (hit) begin
            status[ptr] <= mism ? ST_FAIL : ST_PASS;
            if (mism && !fail_seen) begin
              fail_seen      <= 1'b1;
              first_fail_idx <= ptr;
              first_fail_val <= output_port;
            end
          end else if (num_inst > cur_inst && ptr < LAST_IDX) begin
            ptr <= ptr + 1'b1;
          end
        end
        S_SUMMARY: begin
          if (sum_idx < SUM_END) begin
            case (status[sum_idx[IDX_W-1:0]])
              ST_PASS: pass_cnt  <= pass_cnt + 1'b1;
              ST_FAIL: fail_cnt  <= fail_cnt + 1'b1;
              default: nores_cnt <= nores_cnt + 1'b1;
            endcase
            if (sum_idx != '0 && tbl_inst_mem[sum_idx[IDX_W-1:0]] <= prev_inst) cfg_err <= 1'b1;
            prev_inst <= tbl_inst_mem[sum_idx[IDX_W-1:0]];
            sum_idx   <= sum_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stat_q = ST_NONE;
    if (int'(stat_addr) < NUM_TEST) stat_q = status[stat_addr];
  end

endmodule

// File: tb/tb_wwd_checker.sv
// tb/tb_wwd_checker.sv - directed table-driven testbench for wwd_checker
module tb_wwd_checker;

  localparam int WS = 16;
  localparam int NT = 3;
  localparam int IW = 2;
  localparam int MC = 20;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          tbl_we = 1'b0;
  logic [IW-1:0] tbl_addr = '0;
  logic [WS-1:0] tbl_inst = '0;
  logic [WS-1:0] tbl_ans = '0;
  logic [WS-1:0] num_inst = '0;
  logic [WS-1:0] output_port = '0;
  logic          is_halted = 1'b0;
  logic [IW-1:0] stat_addr = '0;
  logic [1:0]    stat_q;
  logic          busy, done, all_pass, timeout, cfg_err;
  logic [IW:0]   pass_cnt, fail_cnt, nores_cnt;
  logic [IW-1:0] first_fail_idx;
  logic [WS-1:0] first_fail_val;
  logic [CW-1:0] cycle_count;

  wwd_checker #(.WORD_SIZE(WS), .NUM_TEST(NT), .IDX_W(IW), .MAX_CYCLES(MC), .CYC_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_inst(tbl_inst), .tbl_ans(tbl_ans),
    .num_inst(num_inst), .output_port(output_port), .is_halted(is_halted),
    .stat_addr(stat_addr), .stat_q(stat_q), .busy(busy), .done(done),
    .all_pass(all_pass), .timeout(timeout), .cfg_err(cfg_err),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .nores_cnt(nores_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_val(first_fail_val),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WS-1:0] ni;
    logic [WS-1:0] op;
    logic [1:0]    s0;
    logic [1:0]    s1;
    logic [1:0]    s2;
  } vec_t;

  vec_t vecs [27];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_stat(input string nm, input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
    stat_addr = 2'd0; #1; chk({nm, ".s0"}, stat_q, e0);
    stat_addr = 2'd1; #1; chk({nm, ".s1"}, stat_q, e1);
    stat_addr = 2'd2; #1; chk({nm, ".s2"}, stat_q, e2);
  endtask

  task automatic load(input logic [IW-1:0] a, input logic [WS-1:0] ti, input logic [WS-1:0] ta);
    tbl_we = 1'b1; tbl_addr = a; tbl_inst = ti; tbl_ans = ta;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic do_start(input string nm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, ".busy"}, busy, 1);
  endtask

  task automatic do_clear(input string nm);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk({nm, ".clr_done"}, done, 0);
  endtask

  task automatic run_vecs(input string nm, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      num_inst = vecs[i].ni;
      output_port = vecs[i].op;
      @(posedge clk); #1;
      chk_stat($sformatf("%s[%0d]", nm, i - first), vecs[i].s0, vecs[i].s1, vecs[i].s2);
    end
  endtask

  task automatic wait_done(input string nm, input logic halt, output int n);
    is_halted = halt;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    is_halted = 1'b0;
    chk({nm, ".done_seen"}, done, 1);
  endtask

  task automatic chk_sum(input string nm, input int p, input int f, input int nr, input logic ap,
                         input logic to, input logic ce, input int ffi, input int ffv, input int cyc);
    chk({nm, ".pass_cnt"}, pass_cnt, p);
    chk({nm, ".fail_cnt"}, fail_cnt, f);
    chk({nm, ".nores_cnt"}, nores_cnt, nr);
    chk({nm, ".all_pass"}, all_pass, ap);
    chk({nm, ".timeout"}, timeout, to);
    chk({nm, ".cfg_err"}, cfg_err, ce);
    chk({nm, ".ff_idx"}, first_fail_idx, ffi);
    chk({nm, ".ff_val"}, first_fail_val, ffv);
    chk({nm, ".cycles"}, cycle_count, cyc);
    chk({nm, ".busy_low"}, busy, 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".all_pass"}, all_pass, 0);
    chk({nm, ".timeout"}, timeout, 0);
    chk({nm, ".cfg_err"}, cfg_err, 0);
    chk({nm, ".pass_cnt"}, pass_cnt, 0);
    chk({nm, ".fail_cnt"}, fail_cnt, 0);
    chk({nm, ".nores_cnt"}, nores_cnt, 0);
    chk({nm, ".ff_idx"}, first_fail_idx, 0);
    chk({nm, ".ff_val"}, first_fail_val, 0);
    chk({nm, ".cycles"}, cycle_count, 0);
    chk_stat(nm, 0, 0, 0);
  endtask

  task automatic load_good;
    load(2'd0, 16'd3, 16'd0);
    load(2'd1, 16'd5, 16'd0);
    load(2'd2, 16'd7, 16'd2);
  endtask

  int n;

  initial begin
    // Pass sequence: 0..8, output 0 except 2 at num_inst 7.
    vecs[0]  = '{16'd0, 16'd0, 0, 0, 0};
    vecs[1]  = '{16'd1, 16'd0, 0, 0, 0};
    vecs[2]  = '{16'd2, 16'd0, 0, 0, 0};
    vecs[3]  = '{16'd3, 16'd0, 1, 0, 0};
    vecs[4]  = '{16'd4, 16'd0, 1, 0, 0};
    vecs[5]  = '{16'd5, 16'd0, 1, 1, 0};
    vecs[6]  = '{16'd6, 16'd0, 1, 1, 0};
    vecs[7]  = '{16'd7, 16'd2, 1, 1, 1};
    vecs[8]  = '{16'd8, 16'd0, 1, 1, 1};
    // Fail sequence: wrong value 1 at num_inst 5, then another wrong value 3.
    vecs[9]  = '{16'd0, 16'd0, 0, 0, 0};
    vecs[10] = '{16'd1, 16'd0, 0, 0, 0};
    vecs[11] = '{16'd2, 16'd0, 0, 0, 0};
    vecs[12] = '{16'd3, 16'd0, 1, 0, 0};
    vecs[13] = '{16'd4, 16'd0, 1, 0, 0};
    vecs[14] = '{16'd5, 16'd1, 1, 2, 0};
    vecs[15] = '{16'd5, 16'd3, 1, 2, 0};
    vecs[16] = '{16'd6, 16'd0, 1, 2, 0};
    vecs[17] = '{16'd7, 16'd2, 1, 2, 1};
    vecs[18] = '{16'd8, 16'd0, 1, 2, 1};
    // Skip sequence: 4 -> 6 jumps over target 5.
    vecs[19] = '{16'd0, 16'd0, 0, 0, 0};
    vecs[20] = '{16'd1, 16'd0, 0, 0, 0};
    vecs[21] = '{16'd2, 16'd0, 0, 0, 0};
    vecs[22] = '{16'd3, 16'd0, 1, 0, 0};
    vecs[23] = '{16'd4, 16'd0, 1, 0, 0};
    vecs[24] = '{16'd6, 16'd0, 1, 0, 0};
    vecs[25] = '{16'd7, 16'd2, 1, 0, 1};
    vecs[26] = '{16'd8, 16'd0, 1, 0, 1};

    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    load_good();
    do_start("pass");
    run_vecs("pass", 0, 9);
    wait_done("pass", 1'b1, n);
    chk("pass.halt_to_done", n, 5);
    chk_sum("pass", 3, 0, 0, 1, 0, 0, 0, 0, 10);
    do_clear("pass");

    do_start("fail");
    run_vecs("fail", 9, 10);
    wait_done("fail", 1'b1, n);
    chk_sum("fail", 2, 1, 0, 0, 0, 0, 1, 1, 11);
    do_clear("fail");

    do_start("skip");
    run_vecs("skip", 19, 8);
    wait_done("skip", 1'b1, n);
    chk_sum("skip", 2, 0, 1, 0, 0, 0, 0, 0, 9);
    do_clear("skip");

    num_inst = 16'd0; output_port = 16'd0;
    do_start("tmo");
    wait_done("tmo", 1'b0, n);
    chk_sum("tmo", 0, 0, 3, 0, 1, 0, 0, 0, 19);
    do_clear("tmo");

    load(2'd0, 16'd5, 16'd0);
    load(2'd1, 16'd3, 16'd0);
    load(2'd2, 16'd7, 16'd0);
    do_start("cfg");
    wait_done("cfg", 1'b1, n);
    chk_sum("cfg", 0, 0, 3, 0, 0, 1, 0, 0, 1);
    do_clear("cfg");

    load_good();
    do_start("rst");
    run_vecs("rst", 0, 9);
    num_inst = 16'd8; output_port = 16'd0;
    @(posedge clk); #2;
    chk("rst.cycles_before", cycle_count, 10);
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start("rerun");
    run_vecs("rerun", 0, 9);
    wait_done("rerun", 1'b1, n);
    chk_sum("rerun", 3, 0, 0, 1, 0, 0, 0, 0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
